// File: rtl/slow_fast_receiver.sv
// slow_fast_receiver: toggle-handshake receiver that brings words from a slow
// domain into clk_1 and buffers them in a first-word-fall-through FIFO.
// Optional feature: define SLOW_FAST_RX_DROP_CNT_EN to add an 8-bit saturating
// drop_count output that counts words discarded because the FIFO was full.
module slow_fast_receiver #(
    parameter int N           = 12,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                     clk_1,
    input  logic                     reset,
    input  logic [N-1:0]             async_data,
    input  logic                     async_req,
    output logic                     async_ack,
    output logic [N-1:0]             data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
`ifdef SLOW_FAST_RX_DROP_CNT_EN
    output logic [7:0]               drop_count,
`endif
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    // Request synchronizer: s[0] is the only reader of async_req.
    logic [SYNC_STAGES-1:0] s;
    // Previous synchronized level; an edge on the synchronized request is one word.
    logic                   p;
    logic                   evt;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    logic pop;
    logic full;
    logic wr;
    logic drop;

    // Shift async_req through the synchronizer chain.
    always_ff @(posedge clk_1) begin
        if (reset) s <= '0;
        else       s <= {s[SYNC_STAGES-2:0], async_req};
    end

    // Remember last synchronized level for edge detection.
    always_ff @(posedge clk_1) begin
        if (reset) p <= 1'b0;
        else       p <= s[SYNC_STAGES-1];
    end

    assign evt  = s[SYNC_STAGES-1] ^ p;
    assign pop  = out_valid & out_ready;
    assign full = (level == LVL_FULL);
    // A full FIFO still accepts the word if the head leaves on the same edge.
    assign wr   = evt & (~full | pop);
    assign drop = evt & full & ~pop;

    // Acknowledge every event, accepted or dropped, straight from a flop.
    always_ff @(posedge clk_1) begin
        if (reset)    async_ack <= 1'b0;
        else if (evt) async_ack <= ~async_ack;
    end

    // Storage carries no reset; only pointers and level define what is valid.
    always_ff @(posedge clk_1) begin
        if (wr) mem[wptr] <= async_data;
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk_1) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    // Occupancy count; simultaneous write and pop cancel out.
    always_ff @(posedge clk_1) begin
        if (reset) begin
            level <= '0;
        end else begin
            case ({wr, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky drop indicator, cleared only by reset.
    always_ff @(posedge clk_1) begin
        if (reset)     overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef SLOW_FAST_RX_DROP_CNT_EN
    // Saturating count of discarded words.
    always_ff @(posedge clk_1) begin
        if (reset)                          drop_count <= '0;
        else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
`endif

    assign data_out  = mem[rptr];
    assign out_valid = (level != '0);

endmodule
